// File: rtl/emac_tx_framer_pkg.sv
// emac_tx_framer_pkg: shared state encoding, parameter defaults and length helpers for the TX framer.
// No ports. Provides state_t, DEF_MAX_LEN, DEF_TIMEOUT, MOD_ALL, eop_mod(), word_count().
package emac_tx_framer_pkg;

    typedef enum logic [1:0] {IDLE, SEND, ABORT, DRAIN} state_t;

    localparam int unsigned DEF_MAX_LEN = 1518;
    localparam int unsigned DEF_TIMEOUT = 255;

    // A mod value of 0 means all four byte lanes of the word are valid.
    localparam logic [1:0] MOD_ALL = 2'd0;

    function automatic logic [1:0] eop_mod(input logic [15:0] len);
        return len[1:0];
    endfunction

    function automatic logic [15:0] word_count(input logic [15:0] len);
        return 16'((32'(len) + 32'd3) >> 2);
    endfunction

endpackage

// File: rtl/emac_tx_framer_if.sv
// emac_tx_framer_if: command, payload and MAC TX adapter signals of the framer.
// master = framer side, slave = environment side.
// cmd_valid/cmd_ready/cmd_len : per-frame byte-length command
// src_valid/src_ready/src_data: payload word stream
// ff_tx_*                     : words toward the MAC TX adapter; ff_tx_rdy / tx_ff_uflow come back
interface emac_tx_framer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_len;
    logic        src_valid;
    logic        src_ready;
    logic [31:0] src_data;
    logic [31:0] ff_tx_data;
    logic [1:0]  ff_tx_mod;
    logic        ff_tx_sop;
    logic        ff_tx_eop;
    logic        ff_tx_wren;
    logic        ff_tx_err;
    logic        ff_tx_rdy;
    logic        tx_ff_uflow;

    modport master (
        input  cmd_valid, cmd_len, src_valid, src_data, ff_tx_rdy, tx_ff_uflow,
        output cmd_ready, src_ready, ff_tx_data, ff_tx_mod, ff_tx_sop, ff_tx_eop, ff_tx_wren, ff_tx_err
    );

    modport slave (
        output cmd_valid, cmd_len, src_valid, src_data, ff_tx_rdy, tx_ff_uflow,
        input  cmd_ready, src_ready, ff_tx_data, ff_tx_mod, ff_tx_sop, ff_tx_eop, ff_tx_wren, ff_tx_err
    );
endinterface

// File: rtl/emac_tx_framer_cnt.sv
// emac_tx_framer_cnt: 16-bit status counter that sticks at 16'hFFFF.
// Clk_user/Reset: clock and sync active-high clear; inc: count this cycle; count: current value.
module emac_tx_framer_cnt (
    input  logic        Clk_user,
    input  logic        Reset,
    input  logic        inc,
    output logic [15:0] count
);
    always_ff @(posedge Clk_user) begin
        if (Reset)
            count <= '0;
        else if (inc && count != 16'hFFFF)
            count <= count + 16'd1;
    end
endmodule

// File: rtl/emac_tx_framer.sv
// emac_tx_framer: turns a length command plus a 32-bit payload stream into sop/eop-framed MAC TX words.
// Clk_user/Reset: clock and sync active-high reset; bus: emac_tx_framer_if.master;
// busy: not IDLE; frames_sent / frames_aborted: saturating frame counters.
module emac_tx_framer
    import emac_tx_framer_pkg::*;
#(
    parameter int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic             Clk_user,
    input  logic             Reset,
    emac_tx_framer_if.master bus,
    output logic             busy,
    output logic [15:0]      frames_sent,
    output logic [15:0]      frames_aborted
);
    state_t      state;
    logic [1:0]  len_mod;
    logic [15:0] words_left;
    logic [15:0] idle_cnt;
    logic        sent_any;
    logic        cmd_hs, src_hs, last, too_long, timeout_hit, sent_inc, abort_inc;

    assign cmd_hs      = bus.cmd_valid && bus.cmd_ready;
    assign src_hs      = bus.src_valid && bus.src_ready;
    assign last        = words_left == 16'd1;
    assign too_long    = 32'(bus.cmd_len) > MAX_LEN;
    assign timeout_hit = 32'(idle_cnt) + 32'd1 >= TIMEOUT;
    // DRAIN swallows words regardless of downstream space.
    assign bus.src_ready = (state == DRAIN) || (state == SEND && bus.ff_tx_rdy);
    assign busy      = state != IDLE;
    assign sent_inc  = state == SEND && src_hs && last;
    assign abort_inc = (state == ABORT && bus.ff_tx_rdy) ||
                       (state == IDLE && cmd_hs && (bus.cmd_len == 16'd0 || too_long));

    always_ff @(posedge Clk_user) begin
        if (Reset) begin
            state          <= IDLE;
            len_mod        <= '0;
            words_left     <= '0;
            idle_cnt       <= '0;
            sent_any       <= 1'b0;
            bus.cmd_ready  <= 1'b0;
            bus.ff_tx_data <= '0;
            bus.ff_tx_mod  <= '0;
            bus.ff_tx_sop  <= 1'b0;
            bus.ff_tx_eop  <= 1'b0;
            bus.ff_tx_wren <= 1'b0;
            bus.ff_tx_err  <= 1'b0;
        end else begin
            bus.ff_tx_wren <= 1'b0;
            bus.ff_tx_err  <= 1'b0;
            // Every entry into IDLE holds cmd_ready low for one cycle, so a new
            // command is never taken in the same cycle the eop word is presented.
            bus.cmd_ready  <= 1'b0;
            case (state)
                IDLE: begin
                    bus.cmd_ready <= 1'b1;
                    if (cmd_hs) begin
                        len_mod    <= eop_mod(bus.cmd_len);
                        words_left <= word_count(bus.cmd_len);
                        idle_cnt   <= '0;
                        sent_any   <= 1'b0;
                        if (bus.cmd_len != 16'd0) begin
                            state         <= too_long ? DRAIN : SEND;
                            bus.cmd_ready <= 1'b0;
                        end
                    end
                end
                SEND: begin
                    if (src_hs) begin
                        bus.ff_tx_wren <= 1'b1;
                        bus.ff_tx_data <= bus.src_data;
                        bus.ff_tx_sop  <= !sent_any;
                        bus.ff_tx_eop  <= last;
                        bus.ff_tx_mod  <= last ? len_mod : MOD_ALL;
                        words_left     <= words_left - 16'd1;
                        sent_any       <= 1'b1;
                        idle_cnt       <= '0;
                        // A word accepted alongside an underflow is still sent before aborting.
                        if (last)
                            state <= IDLE;
                        else if (bus.tx_ff_uflow)
                            state <= ABORT;
                    end else begin
                        idle_cnt <= idle_cnt + 16'd1;
                        if (timeout_hit || bus.tx_ff_uflow)
                            state <= ABORT;
                    end
                end
                ABORT: begin
                    if (bus.ff_tx_rdy) begin
                        bus.ff_tx_wren <= 1'b1;
                        bus.ff_tx_data <= '0;
                        bus.ff_tx_sop  <= !sent_any;
                        bus.ff_tx_eop  <= 1'b1;
                        bus.ff_tx_mod  <= MOD_ALL;
                        bus.ff_tx_err  <= 1'b1;
                        state          <= words_left != 16'd0 ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (src_hs) begin
                        words_left <= words_left - 16'd1;
                        if (words_left <= 16'd1)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    emac_tx_framer_cnt u_sent (
        .Clk_user(Clk_user),
        .Reset   (Reset),
        .inc     (sent_inc),
        .count   (frames_sent)
    );

    emac_tx_framer_cnt u_aborted (
        .Clk_user(Clk_user),
        .Reset   (Reset),
        .inc     (abort_inc),
        .count   (frames_aborted)
    );
endmodule

// File: tb/tb_emac_tx_framer.sv
// tb_emac_tx_framer: self-checking bench for emac_tx_framer (frame table plus abort/reset sequences).
module tb_emac_tx_framer;
    import emac_tx_framer_pkg::*;

    typedef struct packed {
        logic        err;
        logic        sop;
        logic        eop;
        logic [1:0]  mod;
        logic [31:0] data;
    } obs_t;

    typedef struct {
        logic [15:0] len;
        int          words;
        logic [1:0]  mod;
        int          sent;
        int          aborted;
        int          drained;
    } vec_t;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        busy;
    logic [15:0] frames_sent, frames_aborted;
    int          n_vec = 0;
    int          n_err = 0;
    int          exp_sent = 0;
    int          exp_ab = 0;
    obs_t        exp_q[$];
    obs_t        got_q[$];

    emac_tx_framer_if bus ();

    emac_tx_framer dut (
        .Clk_user      (clk),
        .Reset         (Reset),
        .bus           (bus),
        .busy          (busy),
        .frames_sent   (frames_sent),
        .frames_aborted(frames_aborted)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus.ff_tx_wren)
            got_q.push_back(obs_t'({bus.ff_tx_err, bus.ff_tx_sop, bus.ff_tx_eop, bus.ff_tx_mod, bus.ff_tx_data}));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [15:0] len);
        int t = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = len;
        @(negedge clk);
        while (!bus.cmd_ready && t < 50) begin
            tick();
            @(negedge clk);
            t++;
        end
        check("cmd accepted", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic src_word(input logic [31:0] d, input logic s, input logic e, input logic [1:0] m);
        int t = 0;
        bus.src_valid = 1'b1;
        bus.src_data  = d;
        @(negedge clk);
        while (!bus.src_ready && t < 50) begin
            tick();
            @(negedge clk);
            t++;
        end
        check("src handshake", bus.src_ready, 1);
        if (bus.src_ready)
            exp_q.push_back(obs_t'({1'b0, s, e, m, d}));
        tick();
        bus.src_valid = 1'b0;
        check("wren after hs", bus.ff_tx_wren, 1);
        check("data after hs", bus.ff_tx_data, d);
    endtask

    task automatic drain(output int n);
        int t = 0;
        n = 0;
        bus.src_valid = 1'b1;
        bus.src_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        while (busy && t < 2000) begin
            if (bus.src_ready)
                n++;
            tick();
            @(negedge clk);
            t++;
        end
        bus.src_valid = 1'b0;
        tick();
    endtask

    task automatic wait_err(output int n);
        n = 0;
        while (!bus.ff_tx_err && n < 400) begin
            tick();
            n++;
        end
        check("err word seen", bus.ff_tx_err, 1);
    endtask

    task automatic check_sb(input string tag);
        obs_t e, g;
        repeat (2) tick();
        check({tag, " words"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check({tag, " word"}, g, e);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_cnt(input string tag);
        tick();
        check({tag, " frames_sent"}, frames_sent, exp_sent);
        check({tag, " frames_aborted"}, frames_aborted, exp_ab);
        check({tag, " busy"}, busy, 0);
    endtask

    initial begin
        vec_t vt[12];
        int   n;
        vt[0]  = '{16'd1,    1,   2'd1, 1, 0, 0};
        vt[1]  = '{16'd2,    1,   2'd2, 1, 0, 0};
        vt[2]  = '{16'd3,    1,   2'd3, 1, 0, 0};
        vt[3]  = '{16'd4,    1,   2'd0, 1, 0, 0};
        vt[4]  = '{16'd5,    2,   2'd1, 1, 0, 0};
        vt[5]  = '{16'd8,    2,   2'd0, 1, 0, 0};
        vt[6]  = '{16'd10,   3,   2'd2, 1, 0, 0};
        vt[7]  = '{16'd13,   4,   2'd1, 1, 0, 0};
        vt[8]  = '{16'd0,    0,   2'd0, 0, 1, 0};
        vt[9]  = '{16'd1518, 380, 2'd2, 1, 0, 0};
        vt[10] = '{16'd1519, 0,   2'd0, 0, 1, 380};
        vt[11] = '{16'd1600, 0,   2'd0, 0, 1, 400};

        bus.cmd_valid   = 1'b0;
        bus.cmd_len     = '0;
        bus.src_valid   = 1'b0;
        bus.src_data    = '0;
        bus.ff_tx_rdy   = 1'b1;
        bus.tx_ff_uflow = 1'b0;

        repeat (3) tick();
        Reset = 1'b0;
        check("rst wren", bus.ff_tx_wren, 0);
        check("rst sop/eop/err", {bus.ff_tx_sop, bus.ff_tx_eop, bus.ff_tx_err}, 0);
        check("rst data/mod", {bus.ff_tx_data, bus.ff_tx_mod}, 0);
        check("rst cmd_ready", bus.cmd_ready, 0);
        check("rst src_ready", bus.src_ready, 0);
        check("rst busy", busy, 0);
        check("rst counters", {frames_sent, frames_aborted}, 0);
        tick();
        check("cmd_ready after rst", bus.cmd_ready, 1);

        for (int i = 0; i < 12; i++) begin
            do_cmd(vt[i].len);
            for (int w = 0; w < vt[i].words; w++)
                src_word($urandom, w == 0, w == vt[i].words - 1,
                         w == vt[i].words - 1 ? vt[i].mod : 2'd0);
            if (vt[i].drained > 0) begin
                drain(n);
                check($sformatf("len%0d drained", vt[i].len), n, vt[i].drained);
            end
            exp_sent += vt[i].sent;
            exp_ab   += vt[i].aborted;
            check_sb($sformatf("len%0d", vt[i].len));
            check_cnt($sformatf("len%0d", vt[i].len));
        end

        do_cmd(16'd8);
        src_word(32'h1111_0001, 1'b1, 1'b0, 2'd0);
        bus.ff_tx_rdy = 1'b0;
        bus.src_valid = 1'b1;
        bus.src_data  = 32'h1111_0002;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("gap src_ready", bus.src_ready, 0);
            tick();
            check("gap wren", bus.ff_tx_wren, 0);
        end
        bus.ff_tx_rdy = 1'b1;
        src_word(32'h1111_0002, 1'b0, 1'b1, 2'd0);
        exp_sent++;
        check_sb("rdy gap");
        check_cnt("rdy gap");

        do_cmd(16'd12);
        src_word(32'h2222_0001, 1'b1, 1'b0, 2'd0);
        exp_q.push_back(obs_t'({1'b1, 1'b0, 1'b1, 2'd0, 32'd0}));
        wait_err(n);
        check("timeout cycles", n, 256);
        drain(n);
        check("timeout drained", n, 2);
        exp_ab++;
        check_sb("timeout");
        check_cnt("timeout");

        do_cmd(16'd16);
        src_word(32'h3333_0001, 1'b1, 1'b0, 2'd0);
        bus.tx_ff_uflow = 1'b1;
        src_word(32'h3333_0002, 1'b0, 1'b0, 2'd0);
        bus.tx_ff_uflow = 1'b0;
        exp_q.push_back(obs_t'({1'b1, 1'b0, 1'b1, 2'd0, 32'd0}));
        wait_err(n);
        check("uflow abort latency", n, 1);
        drain(n);
        check("uflow drained", n, 2);
        exp_ab++;
        check_sb("uflow");
        check_cnt("uflow");

        do_cmd(16'd12);
        src_word(32'h4444_0001, 1'b1, 1'b0, 2'd0);
        check_sb("pre-reset");
        bus.src_valid = 1'b1;
        bus.src_data  = 32'h4444_0002;
        Reset = 1'b1;
        tick();
        bus.src_valid = 1'b0;
        Reset = 1'b0;
        check("mid rst wren", bus.ff_tx_wren, 0);
        check("mid rst eop/err", {bus.ff_tx_sop, bus.ff_tx_eop, bus.ff_tx_err}, 0);
        check("mid rst data", bus.ff_tx_data, 0);
        check("mid rst busy", busy, 0);
        check("mid rst readies", {bus.cmd_ready, bus.src_ready}, 0);
        check("mid rst counters", {frames_sent, frames_aborted}, 0);
        exp_sent = 0;
        exp_ab   = 0;
        got_q.delete();
        do_cmd(16'd4);
        src_word(32'h5555_0001, 1'b1, 1'b1, 2'd0);
        exp_sent++;
        check_sb("post-reset");
        check_cnt("post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/emac_tx_framer.md
EMAC_TX_FRAMER -- requirements
Module: emac_tx_framer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 1518, maximum accepted frame length in bytes.
REQ-002 SHALL have parameter TIMEOUT, default 255, idle cycles tolerated mid-frame before abort.
REQ-003 SHALL have port Clk_user  in  1  single clock for all logic.
REQ-004 SHALL have port Reset  in  1  reset, synchronous to Clk_user, active-high.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1, and cmd_len in 16: per-frame byte-length command handshake.
REQ-006 SHALL have ports src_valid in 1, src_ready out 1, and src_data in 32: payload word stream.
REQ-007 SHALL have ports ff_tx_data out 32, ff_tx_mod out 2, ff_tx_sop out 1, ff_tx_eop out 1, ff_tx_wren out 1, and ff_tx_err out 1, all feeding the MAC TX adapter.
REQ-008 SHALL have port ff_tx_rdy  in  1  downstream space available (registered, not AlmostFull).
REQ-009 SHALL have port tx_ff_uflow  in  1  downstream underflow/error indication.
REQ-010 SHALL have ports busy out 1, frames_sent out 16, and frames_aborted out 16: status outputs.

Function
REQ-011 SHALL implement states IDLE, SEND, ABORT, DRAIN.
REQ-012 IDLE: cmd_ready=1; a cmd handshake latches cmd_len and loads the word count ceil(len/4).
REQ-013 IDLE: len 1..MAX_LEN goes to SEND; len 0 stays in IDLE with frames_aborted+1; len>MAX_LEN goes to DRAIN with frames_aborted+1.
REQ-014 SEND: src_ready = ff_tx_rdy; each src handshake SHALL produce ff_tx_wren=1 with src_data exactly one cycle later.
REQ-015 ff_tx_sop SHALL be 1 on the first word of the frame only, and ff_tx_eop SHALL be 1 on the last word only; a 1-word frame has both set.
REQ-016 ff_tx_mod SHALL be 0 on non-eop words; on the eop word it SHALL equal len[1:0], where 0 means 4 valid bytes.
REQ-017 After the eop word, the block SHALL return to IDLE with frames_sent+1; the next cmd is accepted no earlier than the cycle after eop.
REQ-018 ff_tx_wren SHALL be 0 whenever no handshake occurred in the previous cycle; data/mod/sop/eop are don't-care when wren=0.
REQ-019 SEND: a cycle with src_valid=0 or ff_tx_rdy=0 increments the idle counter; any handshake clears it.
REQ-020 SEND: when the idle counter reaches TIMEOUT, or tx_ff_uflow=1 is sampled, the block SHALL enter ABORT.
REQ-021 ABORT: src_ready=0; on the first cycle with ff_tx_rdy=1, the block SHALL emit one word with data=0, eop=1, err=1, mod=0, sop=1 only if no word has yet been sent; it then goes to DRAIN if words remain, else IDLE; frames_aborted+1.
REQ-022 DRAIN: src_ready=1 regardless of ff_tx_rdy; remaining words are discarded with no ff_tx_wren; the block returns to IDLE when the count reaches 0; there is no timeout in DRAIN.
REQ-023 A word whose handshake occurs in the same cycle as the abort condition SHALL still be emitted, and SHALL be counted as sent.
REQ-024 busy SHALL be 1 in any state other than IDLE.
REQ-025 frames_sent and frames_aborted SHALL saturate at 16'hFFFF.
REQ-026 ff_tx_err SHALL be 0 except on the ABORT word.
REQ-027 All ff_tx_* outputs SHALL be registered.

Reset
REQ-028 When Reset=1 at a Clk_user edge, the block SHALL clear to: state IDLE, all ff_tx_* outputs 0, cmd_ready 0, src_ready 0, busy 0, both counters 0, idle and word counters 0.
REQ-029 Reset mid-frame SHALL abandon the frame with no eop emitted; the outputs are quiet the cycle after Reset.
REQ-030 cmd_ready SHALL become 1 on the first cycle after Reset deasserts.

Structure
REQ-031 State encodings, the MAX_LEN/TIMEOUT defaults, and the mod encoding SHALL live in a shared package/include alongside top_define.v.
REQ-032 A sub-module emac_tx_framer_cnt SHALL hold the saturating 16-bit status counter, instantiated twice; all other logic is flat.

Verification
REQ-033 cmd_len=10 with 3 words, src and ff_tx_rdy always 1 -> wren 3 consecutive cycles, sop on word1, eop+mod=2 on word3, frames_sent=1.
REQ-034 cmd_len=8 with ff_tx_rdy dropped for 5 cycles after word1 -> src_ready=0 during the gap, word2 emitted 1 cycle after rdy returns, no err.
REQ-035 cmd_len=12, src_valid held 0 after word1 for 255 cycles -> err word with eop=1, sop=0, then DRAIN accepts 2 words silently, frames_aborted=1.
REQ-036 cmd_len=0 then cmd_len=1600 plus 400 words -> no wren at all, frames_aborted=2, back in IDLE after the 400th word.
REQ-037 tx_ff_uflow pulsed on the same cycle as word2 handshake of a 16-byte frame -> word2 emitted, then err/eop word, 2 words drained.
REQ-038 Reset asserted mid-SEND -> outputs 0 the next cycle, counters 0; a new cmd_len=4 frame is sent cleanly afterwards.
